// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Holds the fetch FSM encoding and the queued entry layout.
package fetch_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Clear the byte offset so fetches stay word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// Small synchronous FIFO used as the fetch queue storage.
// Flush empties it in one cycle; storage itself is never reset.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];

    // Pointer and occupancy tracking; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues one memory request at a time,
// queues returned words with their PC, and handles redirects.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall_d,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_vld,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcplus4
);

    localparam int             CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    fetch_state_e  state;
    logic          req_q;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   redirect_pc;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign redirect_pc = align_word(i_redirect_pc);
    assign o_vld       = (count != '0);
    assign push        = (state == REQ) && i_imem_ack && !i_redirect;
    assign pop         = o_vld && !i_stall_d && !i_redirect;
    assign count_next  = count + CW'(push) - CW'(pop);
    assign push_entry  = '{pc: fetch_pc, instr: i_imem_rdata};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .flush (i_redirect),
        .wdata (push_entry),
        .rdata (head),
        .count (count)
    );

    assign o_pc        = head.pc;
    assign o_pcplus4   = head.pc + 32'd4;
    assign o_instr     = o_vld ? head.instr : NOP_INSTR;
    assign o_imem_req  = req_q;
    assign o_imem_addr = req_addr;

    // Fetch FSM: request sequencing, PC advance and redirect handling.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_redirect) begin
                        fetch_pc <= redirect_pc;
                        req_addr <= redirect_pc;
                        state    <= REQ;
                        req_q    <= 1'b1;
                    end else if (count < FULL) begin
                        req_addr <= fetch_pc;
                        state    <= REQ;
                        req_q    <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_redirect) begin
                        fetch_pc <= redirect_pc;
                        if (i_imem_ack) begin
                            req_addr <= redirect_pc;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (i_imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        req_addr <= fetch_pc + 32'd4;
                        if (count_next == FULL) begin
                            state <= IDLE;
                            req_q <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (i_redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (i_imem_ack) begin
                        state    <= REQ;
                        req_addr <= i_redirect ? redirect_pc : fetch_pc;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer with a latency-configurable
// instruction memory and a program-order reference model.
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        i_stall_d = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_vld;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pcplus4;

    int compared   = 0;
    int mismatched = 0;

    int lat         = 0;
    bit mem_en      = 1'b0;
    int inject_req  = 0;
    int inject_done = 0;
    int ack_count   = 0;

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_stall_d     (i_stall_d),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_vld         (o_vld),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_pcplus4     (o_pcplus4)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Memory model: acks the pending request after 'lat' extra cycles.
    initial begin : memory
        int wait_cnt;
        wait_cnt     = 0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = '0;
        forever begin
            @(negedge i_clk);
            #1;
            i_imem_ack = 1'b0;
            if (inject_req != inject_done) begin
                inject_done  = inject_req;
                i_imem_ack   = 1'b1;
                i_imem_rdata = 32'hdead_beef;
            end else if (mem_en && o_imem_req && !i_rst) begin
                if (wait_cnt >= lat) begin
                    i_imem_ack   = 1'b1;
                    i_imem_rdata = word_of(o_imem_addr);
                    ack_count    = ack_count + 1;
                    wait_cnt     = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst      = 1'b1;
        i_redirect = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_en = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        compared++;
        if (o_imem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_req: got %b expected 0", o_imem_req);
        end
        compared++;
        if (o_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_vld: got %b expected 0", o_vld);
        end
        compared++;
        if (o_imem_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL reset_addr: got %h expected %h", o_imem_addr, RESET_PC);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        compared++;
        if (o_imem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL req_at_deassert: got %b expected 0", o_imem_req);
        end
        @(negedge i_clk);
        compared++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL first_req: req %b addr %h expected 1 %h",
                     o_imem_req, o_imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        int n;
        mem_en    = 1'b1;
        lat       = 0;
        i_stall_d = 1'b0;
        apply_reset();
        n = 0;
        while (!o_vld && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        exp = RESET_PC;
        for (int k = 0; k < 8; k++) begin
            compared++;
            if (o_vld !== 1'b1 || o_pc !== exp || o_instr !== word_of(exp)) begin
                mismatched++;
                $display("FAIL seq_%0d: vld %b pc %h instr %h expected 1 %h %h",
                         k, o_vld, o_pc, o_instr, exp, word_of(exp));
            end
            exp += 32'd4;
            @(negedge i_clk);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int a0;
        int pops;
        mem_en    = 1'b1;
        lat       = 0;
        i_stall_d = 1'b1;
        apply_reset();
        a0 = ack_count;
        repeat (10) @(negedge i_clk);
        compared++;
        if (o_imem_req !== 1'b0 || ack_count - a0 != DEPTH) begin
            mismatched++;
            $display("FAIL stall_full: req %b acks %0d expected 0 %0d",
                     o_imem_req, ack_count - a0, DEPTH);
        end
        compared++;
        if (o_vld !== 1'b1 || o_pc !== RESET_PC) begin
            mismatched++;
            $display("FAIL stall_head: vld %b pc %h expected 1 %h", o_vld, o_pc, RESET_PC);
        end
        i_stall_d = 1'b0;
        exp  = RESET_PC;
        pops = 0;
        repeat (12) begin
            if (o_vld) begin
                compared++;
                if (o_pc !== exp || o_instr !== word_of(exp)) begin
                    mismatched++;
                    $display("FAIL stall_resume: pc %h instr %h expected %h %h",
                             o_pc, o_instr, exp, word_of(exp));
                end
                exp += 32'd4;
                pops++;
            end
            @(negedge i_clk);
        end
        compared++;
        if (pops < 6) begin
            mismatched++;
            $display("FAIL stall_progress: got %0d pops expected >= 6", pops);
        end
    endtask

    task automatic test_redirect_discard();
        int n;
        mem_en    = 1'b1;
        lat       = 3;
        i_stall_d = 1'b1;
        apply_reset();
        n = 0;
        while (!(o_imem_req && o_imem_addr == 32'h8) && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        compared++;
        if (!(o_imem_req && o_imem_addr == 32'h8)) begin
            mismatched++;
            $display("FAIL disc_setup: req %b addr %h expected 1 00000008", o_imem_req, o_imem_addr);
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        @(negedge i_clk);
        i_redirect = 1'b0;
        i_stall_d  = 1'b0;
        compared++;
        if (o_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin
            mismatched++;
            $display("FAIL disc_hold: vld %b req %b addr %h expected 0 1 00000008",
                     o_vld, o_imem_req, o_imem_addr);
        end
        n = 0;
        while (!o_vld && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        compared++;
        if (o_vld !== 1'b1 || o_pc !== 32'h100 || o_instr !== word_of(32'h100)) begin
            mismatched++;
            $display("FAIL disc_first: vld %b pc %h instr %h expected 1 00000100 %h",
                     o_vld, o_pc, o_instr, word_of(32'h100));
        end
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_vld && n < 30);
        compared++;
        if (o_vld !== 1'b1 || o_pc !== 32'h104) begin
            mismatched++;
            $display("FAIL disc_second: vld %b pc %h expected 1 00000104", o_vld, o_pc);
        end
    endtask

    task automatic test_redirect_ack();
        int n;
        mem_en    = 1'b1;
        lat       = 0;
        i_stall_d = 1'b0;
        apply_reset();
        n = 0;
        while (!o_imem_req && n < 5) begin
            @(negedge i_clk);
            n++;
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h203;
        @(negedge i_clk);
        i_redirect = 1'b0;
        compared++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h200 || o_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL rack_req: req %b addr %h vld %b expected 1 00000200 0",
                     o_imem_req, o_imem_addr, o_vld);
        end
        @(negedge i_clk);
        compared++;
        if (o_vld !== 1'b1 || o_pc !== 32'h200 || o_pcplus4 !== 32'h204
            || o_instr !== word_of(32'h200)) begin
            mismatched++;
            $display("FAIL rack_head: vld %b pc %h pc4 %h instr %h expected 1 00000200 00000204 %h",
                     o_vld, o_pc, o_pcplus4, o_instr, word_of(32'h200));
        end
    endtask

    task automatic test_push_pop();
        int n;
        mem_en    = 1'b1;
        lat       = 3;
        i_stall_d = 1'b1;
        apply_reset();
        n = 0;
        while (!(o_imem_req && o_imem_addr == 32'h8) && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        repeat (3) @(negedge i_clk);
        compared++;
        if (o_vld !== 1'b1 || o_pc !== 32'h0) begin
            mismatched++;
            $display("FAIL pp_head0: vld %b pc %h expected 1 00000000", o_vld, o_pc);
        end
        i_stall_d = 1'b0;
        @(negedge i_clk);
        i_stall_d = 1'b1;
        mem_en    = 1'b0;
        compared++;
        if (o_vld !== 1'b1 || o_pc !== 32'h4) begin
            mismatched++;
            $display("FAIL pp_head1: vld %b pc %h expected 1 00000004", o_vld, o_pc);
        end
        @(negedge i_clk);
        i_stall_d = 1'b0;
        @(negedge i_clk);
        compared++;
        if (o_vld !== 1'b1 || o_pc !== 32'h8) begin
            mismatched++;
            $display("FAIL pp_head2: vld %b pc %h expected 1 00000008", o_vld, o_pc);
        end
        @(negedge i_clk);
        compared++;
        if (o_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL pp_empty: vld %b expected 0", o_vld);
        end
    endtask

    task automatic test_reset_mid();
        mem_en    = 1'b0;
        i_stall_d = 1'b0;
        apply_reset();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        @(negedge i_clk);
        i_redirect = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        compared++;
        if (o_imem_req !== 1'b0 || o_vld !== 1'b0 || o_imem_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL rmid_reset: req %b vld %b addr %h expected 0 0 %h",
                     o_imem_req, o_vld, o_imem_addr, RESET_PC);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        inject_req++;
        @(negedge i_clk);
        compared++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC || o_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL rmid_first: req %b addr %h vld %b expected 1 %h 0",
                     o_imem_req, o_imem_addr, o_vld, RESET_PC);
        end
        @(negedge i_clk);
        compared++;
        if (o_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL rmid_stale: vld %b expected 0", o_vld);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        logic [31:0] prev_addr;
        bit          prev_req;
        bit          redir_pend;
        bit          redir;
        int          pops;
        mem_en    = 1'b1;
        lat       = 0;
        i_stall_d = 1'b0;
        apply_reset();
        exp        = RESET_PC;
        prev_req   = 1'b0;
        prev_addr  = '0;
        redir_pend = 1'b0;
        pops       = 0;
        for (int i = 0; i < 600; i++) begin
            if (redir_pend) begin
                compared++;
                if (o_vld !== 1'b0) begin
                    mismatched++;
                    $display("FAIL rnd_flush_%0d: vld %b expected 0", i, o_vld);
                end
            end else if (o_vld) begin
                compared++;
                if (o_pc !== exp || o_instr !== word_of(exp) || o_pcplus4 !== exp + 32'd4) begin
                    mismatched++;
                    $display("FAIL rnd_head_%0d: pc %h instr %h pc4 %h expected %h %h %h",
                             i, o_pc, o_instr, o_pcplus4, exp, word_of(exp), exp + 32'd4);
                end
            end
            if (o_imem_req) begin
                compared++;
                if (o_imem_addr[1:0] !== 2'b00
                    || (prev_req && !i_imem_ack && o_imem_addr !== prev_addr)) begin
                    mismatched++;
                    $display("FAIL rnd_addr_%0d: addr %h prev %h", i, o_imem_addr, prev_addr);
                end
            end
            prev_req  = o_imem_req;
            prev_addr = o_imem_addr;
            if ($urandom_range(0, 19) == 0) begin
                lat = $urandom_range(0, 3);
            end
            i_stall_d = ($urandom_range(0, 9) < 3);
            redir     = ($urandom_range(0, 29) == 0) || (i == 300);
            i_redirect    = redir;
            i_redirect_pc = (i == 300) ? 32'hFFFF_FFF6 : $urandom;
            if (redir) begin
                exp = i_redirect_pc & ~32'd3;
            end else if (o_vld && !i_stall_d) begin
                exp += 32'd4;
                pops++;
            end
            redir_pend = redir;
            @(negedge i_clk);
        end
        i_redirect = 1'b0;
        compared++;
        if (pops < 100) begin
            mismatched++;
            $display("FAIL rnd_progress: got %0d pops expected >= 100", pops);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_discard();
        test_redirect_ack();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
